fft_loop_test_nios2_gen2_0_cpu_debug_mon_access: RTL
====================================================

FFT_LOOP_TEST_NIOS2_GEN2_0_CPU_DEBUG_MON_ACCESS -- requirements
Module: fft_loop_test_nios2_gen2_0_cpu_debug_mon_access

Interface
REQ-001 Parameter: ADDR_W, default 8, debug RAM word-address width; legal range 1..8; the address field is jdo[26+ADDR_W-1:26].
REQ-002 The block SHALL use one clock and a synchronous, active-low reset, named as follows:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
REQ-003 JTAG-side (sysclk-domain) inputs and outputs SHALL be:
- jdo  in  38  debug data word.
- take_action_ocimem_a  in  1  address-load command pulse.
- take_no_action_ocimem_a  in  1  read-next command pulse.
- take_action_ocimem_b  in  1  write-next command pulse.
- MonDReg  out  32  monitor data register.
- monitor_ready  out  1  last JTAG command complete.
- monitor_error  out  1  sticky command-overflow flag.
REQ-004 CPU slave ports SHALL be:
- cpu_address  in  ADDR_W  word address.
- cpu_read  in  1  read request.
- cpu_write  in  1  write request.
- cpu_writedata  in  32  write data.
- cpu_readdata  out  32  read data.
- cpu_waitrequest  out  1  stall.
REQ-005 RAM port SHALL be:
- ram_addr  out  ADDR_W  address.
- ram_wdata  out  32  write data.
- ram_we  out  1  write enable.
- ram_rdata  in  32  read data, valid one cycle after ram_addr.

Function
REQ-006 Command decode (priority b > a > no_action when pulses coincide):
- ocimem_a: MonAReg <= address field; if jdo[25]=1, read at the new address; if jdo[35]=1, clear monitor_error.
- no_action_ocimem_a: read at MonAReg.
- ocimem_b: write jdo[34:3] at MonAReg.
REQ-007 FSM states: IDLE, JRD, JCAP, JWR, CRD, CCAP, CWR.
REQ-008 A command accepted in IDLE at cycle C SHALL reach its result as follows:
- Read: JRD at C+1 (ram_addr=MonAReg, ram_we=0), then JCAP at C+2. At the end of C+2: MonDReg <= ram_rdata, monitor_ready <= 1, MonAReg+1. Result visible at C+3.
- Write: JWR at C+1 (ram_we=1). At the end of C+1: MonAReg+1, monitor_ready <= 1.
- Address load without read: completes at the end of C; monitor_ready <= 1 at C+1.
REQ-009 monitor_ready SHALL clear at the end of the cycle in which any JTAG command is accepted or pended.
REQ-010 A command arriving while not IDLE SHALL be stored in a 1-deep pending register. If the pending register is already full, the new command SHALL be dropped and monitor_error set; the pending command is kept.
REQ-011 MonAReg increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-012 CPU read: CRD (ram_addr=cpu_address), then CCAP (cpu_readdata <= ram_rdata; cpu_waitrequest=0 for exactly that cycle).
REQ-013 CPU write: CWR (ram_we=1; cpu_waitrequest=0 for that cycle).
REQ-014 cpu_waitrequest SHALL be 1 whenever a CPU request is present and the FSM is not in CCAP or CWR. The CPU holds its request until waitrequest is 0. cpu_read and cpu_write both high SHALL be treated as a write.
REQ-015 Arbitration in IDLE:
- A JTAG command (new or pending) SHALL win over a simultaneous CPU request.
- After any JTAG operation completes, a waiting CPU request SHALL be served before the next JTAG command.
- A pending JTAG command SHALL be served before a newly arriving JTAG pulse.
REQ-016 ram_we SHALL be 1 only in JWR or CWR. ram_addr and ram_wdata SHALL be don't-care in IDLE but driven stably within each state.

Reset
REQ-017 With reset_n=0 at a clock edge, the following SHALL hold: state=IDLE; MonAReg=0; MonDReg=0; monitor_ready=0; monitor_error=0; pending empty; cpu_readdata=0; ram_we=0.
REQ-018 Reset asserted mid-operation SHALL abort that operation without completing it: no write, no MonAReg increment. Any pending command SHALL be discarded.
REQ-019 Command pulses during reset SHALL be ignored.

Verification
REQ-020 ocimem_a with jdo[33:26]=0x10 and jdo[25]=1, RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF and monitor_ready=1 at C+3; MonAReg=0x11.
REQ-021 MonAReg=0xFF, ocimem_b with jdo[34:3]=0x12345678 -> RAM[0xFF]=0x12345678; MonAReg=0x00; monitor_ready=1 at C+2.
REQ-022 Three JTAG read pulses on consecutive cycles from IDLE -> first served, second pended, third dropped; monitor_error=1; a subsequent ocimem_a with jdo[35]=1 -> monitor_error=0.
REQ-023 cpu_read at 0x05 and no_action_ocimem_a in the same cycle -> JTAG served first; cpu_readdata=RAM[0x05] with waitrequest low at CCAP; a further JTAG pulse arriving during the CPU access is served after it.
REQ-024 reset_n=0 during JWR of a write to 0x20 -> RAM[0x20] unchanged if reset precedes the edge; all outputs at reset values next cycle; pending empty.
REQ-025 CPU write 0xA5A5A5A5 to 0x03, then CPU read 0x03 -> cpu_readdata=0xA5A5A5A5; each access completes in 1 or 2 cycles respectively with no JTAG traffic.

Source files
------------

// File: rtl/fft_loop_test_nios2_gen2_0_cpu_debug_mon_access.sv
// Debug-monitor RAM access arbiter: JTAG commands (read/write/address-load) and a CPU slave share one RAM port.
// JTAG read 3 cycles, write 2, address-load 1; CPU stalled via waitrequest, 1-deep JTAG pending slot, overflow flagged.
module fft_loop_test_nios2_gen2_0_cpu_debug_mon_access #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, JRD, JCAP, JWR, CRD, CCAP, CWR} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_NA, CMD_B} cmd_t;

  state_t            state, state_nxt;
  cmd_t              new_cmd, sel_cmd, pend_cmd;
  logic [37:0]       sel_jdo, pend_jdo;
  logic              pend_vld;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       wdata_q;
  logic [31:0]       readdata_q;
  logic              cpu_prio;
  logic              cpu_req;
  logic              serve_pend, serve_new, serve_cpu, serve_j;
  logic              pend_new, drop_new;
  logic              aload_only, j_done;
  logic              unused_jdo;

  assign cpu_req    = cpu_read | cpu_write;
  assign unused_jdo = ^{jdo, pend_jdo};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    new_cmd    = CMD_NONE;
    sel_cmd    = pend_cmd;
    sel_jdo    = pend_jdo;
    serve_pend = 1'b0;
    serve_new  = 1'b0;
    serve_cpu  = 1'b0;
    pend_new   = 1'b0;
    drop_new   = 1'b0;

    if (take_action_ocimem_b)         new_cmd = CMD_B;
    else if (take_action_ocimem_a)    new_cmd = CMD_A;
    else if (take_no_action_ocimem_a) new_cmd = CMD_NA;

    case (state)
      IDLE: begin
        // A CPU that waited through a JTAG op goes first; otherwise JTAG wins, pending before new.
        if (cpu_prio && cpu_req)      serve_cpu = 1'b1;
        else if (pend_vld)            serve_pend = 1'b1;
        else if (new_cmd != CMD_NONE) begin
          serve_new = 1'b1;
          sel_cmd   = new_cmd;
          sel_jdo   = jdo;
        end else if (cpu_req)         serve_cpu = 1'b1;

        if (serve_cpu) begin
          state_nxt = cpu_write ? CWR : CRD;
        end else if (serve_pend || serve_new) begin
          case (sel_cmd)
            CMD_B:   state_nxt = JWR;
            CMD_NA:  state_nxt = JRD;
            CMD_A:   state_nxt = sel_jdo[25] ? JRD : IDLE;
            default: state_nxt = IDLE;
          endcase
        end
      end
      JRD:     state_nxt = JCAP;
      JCAP:    state_nxt = IDLE;
      JWR:     state_nxt = IDLE;
      CRD:     state_nxt = CCAP;
      CCAP:    state_nxt = IDLE;
      CWR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // The slot is free if empty or being drained this very cycle.
    if (new_cmd != CMD_NONE && !serve_new) begin
      if (!pend_vld || serve_pend) pend_new = 1'b1;
      else                         drop_new = 1'b1;
    end
  end

  assign serve_j    = serve_pend | serve_new;
  assign aload_only = serve_j && (sel_cmd == CMD_A) && !sel_jdo[25];
  assign j_done     = (state == JCAP) || (state == JWR) || aload_only;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      pend_vld      <= 1'b0;
      pend_cmd      <= CMD_NONE;
      pend_jdo      <= '0;
      wdata_q       <= '0;
      readdata_q    <= '0;
      cpu_prio      <= 1'b0;
    end else begin
      if (serve_j && sel_cmd == CMD_A) begin
        mon_a_reg <= sel_jdo[26 +: ADDR_W];
        if (sel_jdo[35]) monitor_error <= 1'b0;
      end
      if (serve_j && sel_cmd == CMD_B) wdata_q <= sel_jdo[34:3];
      if (drop_new) monitor_error <= 1'b1;

      if (pend_new) begin
        pend_vld <= 1'b1;
        pend_cmd <= new_cmd;
        pend_jdo <= jdo;
      end else if (serve_pend) begin
        pend_vld <= 1'b0;
      end

      if (state == JCAP) MonDReg <= ram_rdata;
      if (state == JCAP || state == JWR) mon_a_reg <= mon_a_reg + ADDR_W'(1);

      // A freshly accepted or pended command overrides any completion this cycle.
      if (j_done) monitor_ready <= 1'b1;
      if (pend_new || (serve_j && !aload_only)) monitor_ready <= 1'b0;

      if (serve_cpu)   cpu_prio <= 1'b0;
      else if (j_done) cpu_prio <= cpu_req;

      if (state == CCAP) readdata_q <= ram_rdata;
    end
  end

  // Write enable gated by reset so an aborted write never reaches the RAM.
  assign ram_we          = reset_n && (state == JWR || state == CWR);
  assign ram_addr        = (state == CRD || state == CCAP || state == CWR) ? cpu_address : mon_a_reg;
  assign ram_wdata       = (state == CWR) ? cpu_writedata : wdata_q;
  assign cpu_waitrequest = cpu_req && !(state == CCAP || state == CWR);
  assign cpu_readdata    = (state == CCAP) ? ram_rdata : readdata_q;

endmodule
